// File: rtl/wb_pipe_ctrl.sv
// Writeback controller: decodes a register-file write intent and carries it
// down an NSTAGE-deep stall/flush pipeline. Optional RAW hazard flag under WB_HAZARD_EN.
module wb_pipe_ctrl #(
    parameter int          RA_W      = 3,
    parameter int          NSTAGE    = 3,
    parameter logic [15:0] OP3_WMASK = 16'h1F7F
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [1:0]      op1,
    input  logic [3:0]      op3,
    input  logic [RA_W-1:0] rd_rb,
    input  logic [RA_W-1:0] ra_op2,
    input  logic [RA_W-1:0] src_a,
    input  logic [RA_W-1:0] src_b,
    output logic [RA_W-1:0] wb_addr,
    output logic            wb_en,
    output logic            hazard
);

    typedef struct packed {
        logic            v;
        logic            we;
        logic [RA_W-1:0] addr;
    } stage_t;

    stage_t [NSTAGE-1:0] stg_q, stg_d;
    logic                we_dec;
    logic [RA_W-1:0]     addr_dec;

    always_comb begin
        we_dec   = 1'b0;
        addr_dec = rd_rb;
        unique case (op1)
            2'b00: begin
                we_dec   = 1'b1;
                addr_dec = ra_op2;
            end
            2'b01: we_dec = 1'b0;
            2'b10: we_dec = (ra_op2 == '0);
            2'b11: we_dec = OP3_WMASK[op3];
            default: we_dec = 1'b0;
        endcase
    end

    always_comb begin
        stg_d = stg_q;
        if (!stall) begin
            stg_d[0] = {in_valid, we_dec, addr_dec};
            for (int n = 1; n < NSTAGE; n++) stg_d[n] = stg_q[n-1];
        end
        if (flush) begin
            for (int n = 0; n < NSTAGE - 1; n++) stg_d[n].v = 1'b0;
            // The entry leaving stage NSTAGE-2 is on the wrong path too.
            if (!stall) stg_d[NSTAGE-1].v = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stg_q <= '0;
        else        stg_q <= stg_d;
    end

    assign wb_en   = stg_q[NSTAGE-1].v & stg_q[NSTAGE-1].we & ~stall;
    assign wb_addr = stg_q[NSTAGE-1].addr;

`ifdef WB_HAZARD_EN
    logic hit;

    // Last stage is excluded: the register file writes before it reads.
    always_comb begin
        hit = 1'b0;
        for (int n = 0; n < NSTAGE - 1; n++) begin
            if (stg_q[n].v && stg_q[n].we &&
                (stg_q[n].addr == src_a || stg_q[n].addr == src_b))
                hit = 1'b1;
        end
    end

    assign hazard = in_valid & hit;
`else
    logic unused_src;
    assign unused_src = ^{src_a, src_b};
    assign hazard     = 1'b0;
`endif

endmodule

// File: tb/tb_wb_pipe_ctrl.sv
// Directed bench for wb_pipe_ctrl: vector table plus stall, flush, reset and hazard sequences.
module tb_wb_pipe_ctrl;

    localparam int RA_W   = 3;
    localparam int NSTAGE = 3;

    logic            clk;
    logic            rst_n;
    logic            in_valid, stall, flush;
    logic [1:0]      op1;
    logic [3:0]      op3;
    logic [RA_W-1:0] rd_rb, ra_op2, src_a, src_b;
    logic [RA_W-1:0] wb_addr;
    logic            wb_en, hazard;

    int checks   = 0;
    int failures = 0;

    wb_pipe_ctrl #(.RA_W(RA_W), .NSTAGE(NSTAGE), .OP3_WMASK(16'h1F7F)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .stall    (stall),
        .flush    (flush),
        .op1      (op1),
        .op3      (op3),
        .rd_rb    (rd_rb),
        .ra_op2   (ra_op2),
        .src_a    (src_a),
        .src_b    (src_b),
        .wb_addr  (wb_addr),
        .wb_en    (wb_en),
        .hazard   (hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [1:0]      op1;
        logic [3:0]      op3;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] ra;
        logic            en;
        logic [RA_W-1:0] addr;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [1:0] o1, input logic [3:0] o3,
                       input logic [RA_W-1:0] rd, input logic [RA_W-1:0] ra);
        op1    = o1;
        op3    = o3;
        rd_rb  = rd;
        ra_op2 = ra;
    endtask

    function automatic logic hz_exp(input logic h);
`ifdef WB_HAZARD_EN
        return h;
`else
        return 1'b0 & h;
`endif
    endfunction

    initial begin
        vecs[0] = '{"alu r5",     2'b11, 4'd0,  3'd5, 3'd0, 1'b1, 3'd5};
        vecs[1] = '{"cmp nowr",   2'b11, 4'd7,  3'd5, 3'd0, 1'b0, 3'd0};
        vecs[2] = '{"ldi r3",     2'b10, 4'd0,  3'd3, 3'd0, 1'b1, 3'd3};
        vecs[3] = '{"ldi ra4",    2'b10, 4'd0,  3'd3, 3'd4, 1'b0, 3'd0};
        vecs[4] = '{"load r6",    2'b00, 4'd0,  3'd1, 3'd6, 1'b1, 3'd6};
        vecs[5] = '{"store",      2'b01, 4'd0,  3'd2, 3'd0, 1'b0, 3'd0};
        vecs[6] = '{"op3_12 r0",  2'b11, 4'd12, 3'd0, 3'd0, 1'b1, 3'd0};
        vecs[7] = '{"op3_13 no",  2'b11, 4'd13, 3'd7, 3'd0, 1'b0, 3'd0};
        vecs[8] = '{"op3_8 r7",   2'b11, 4'd8,  3'd7, 3'd2, 1'b1, 3'd7};

        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        src_a = '0; src_b = '0;
        put(2'b00, 4'd0, 3'd0, 3'd0);
        #12;
        chk("reset wb_en", {7'd0, wb_en}, 8'd0);
        chk("reset wb_addr", {5'd0, wb_addr}, 8'd0);
        chk("reset hazard", {7'd0, hazard}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single instructions: strobe exactly NSTAGE edges after presentation.
        for (int v = 0; v < 9; v++) begin
            put(vecs[v].op1, vecs[v].op3, vecs[v].rd, vecs[v].ra);
            in_valid = 1'b1;
            for (int i = 1; i <= NSTAGE + 1; i++) begin
                tick();
                in_valid = 1'b0;
                chk({vecs[v].name, " en"}, {7'd0, wb_en},
                    {7'd0, (i == NSTAGE) ? vecs[v].en : 1'b0});
                if (i == NSTAGE && vecs[v].en)
                    chk({vecs[v].name, " addr"}, {5'd0, wb_addr}, {5'd0, vecs[v].addr});
            end
        end

        // Stall with r2 at the last stage; in_valid during stall is ignored.
        put(2'b11, 4'd0, 3'd2, 3'd0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 1; i < NSTAGE; i++) tick();
        stall = 1'b1;
        put(2'b11, 4'd0, 3'd7, 3'd0);
        in_valid = 1'b1;
        #1;
        chk("stall en0", {7'd0, wb_en}, 8'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall hold en", {7'd0, wb_en}, 8'd0);
        end
        stall = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("stall release en", {7'd0, wb_en}, 8'd1);
        chk("stall release addr", {5'd0, wb_addr}, 8'd2);
        for (int i = 0; i < NSTAGE + 1; i++) begin
            tick();
            chk("stall single strobe", {7'd0, wb_en}, 8'd0);
        end

        // Back-to-back r1, r2, r4; flush while r4 sits in stage 1.
        put(2'b11, 4'd0, 3'd1, 3'd0); in_valid = 1'b1; tick();
        put(2'b11, 4'd0, 3'd2, 3'd0); tick();
        put(2'b11, 4'd0, 3'd4, 3'd0); tick();
        in_valid = 1'b0;
        chk("flush r1 en", {7'd0, wb_en}, 8'd1);
        chk("flush r1 addr", {5'd0, wb_addr}, 8'd1);
        tick();
        flush = 1'b1;
        #1;
        chk("flush r2 en", {7'd0, wb_en}, 8'd1);
        chk("flush r2 addr", {5'd0, wb_addr}, 8'd2);
        tick();
        flush = 1'b0;
        for (int i = 0; i < NSTAGE; i++) begin
            chk("flush r4 killed", {7'd0, wb_en}, 8'd0);
            tick();
        end

        // Flush during stall: last stage holds r1, younger r2 is killed.
        put(2'b11, 4'd0, 3'd1, 3'd0); in_valid = 1'b1; tick();
        put(2'b11, 4'd0, 3'd2, 3'd0); tick();
        in_valid = 1'b0; tick();
        stall = 1'b1; flush = 1'b1;
        #1;
        chk("fs stalled en", {7'd0, wb_en}, 8'd0);
        tick();
        stall = 1'b0; flush = 1'b0;
        #1;
        chk("fs held en", {7'd0, wb_en}, 8'd1);
        chk("fs held addr", {5'd0, wb_addr}, 8'd1);
        tick();
        chk("fs r2 killed a", {7'd0, wb_en}, 8'd0);
        tick();
        chk("fs r2 killed b", {7'd0, wb_en}, 8'd0);

        // Hazard: r3 writer walking down the pipe, store issuing alongside.
        put(2'b11, 4'd0, 3'd3, 3'd0); in_valid = 1'b1; tick();
        put(2'b01, 4'd0, 3'd0, 3'd0);
        src_a = 3'd3; src_b = 3'd0; #1;
        chk("hz st0 src_a", {7'd0, hazard}, {7'd0, hz_exp(1'b1)});
        src_a = 3'd2; src_b = 3'd3; #1;
        chk("hz st0 src_b", {7'd0, hazard}, {7'd0, hz_exp(1'b1)});
        src_a = 3'd1; src_b = 3'd2; #1;
        chk("hz no match", {7'd0, hazard}, 8'd0);
        in_valid = 1'b0; src_a = 3'd3; #1;
        chk("hz no in_valid", {7'd0, hazard}, 8'd0);
        tick();
        in_valid = 1'b1; #1;
        chk("hz st1", {7'd0, hazard}, {7'd0, hz_exp(1'b1)});
        in_valid = 1'b0;
        tick();
        in_valid = 1'b1; #1;
        chk("hz last excluded", {7'd0, hazard}, 8'd0);
        chk("hz last wb_en", {7'd0, wb_en}, 8'd1);
        in_valid = 1'b0;
        tick();

        // Reset with a write at the last stage drops it immediately.
        put(2'b11, 4'd0, 3'd5, 3'd0); in_valid = 1'b1; tick();
        in_valid = 1'b0;
        for (int i = 1; i < NSTAGE; i++) tick();
        chk("pre-reset en", {7'd0, wb_en}, 8'd1);
        rst_n = 1'b0;
        in_valid = 1'b1; src_a = 3'd5;
        #1;
        chk("mid reset en", {7'd0, wb_en}, 8'd0);
        chk("mid reset addr", {5'd0, wb_addr}, 8'd0);
        chk("mid reset hazard", {7'd0, hazard}, 8'd0);
        in_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < NSTAGE + 1; i++) begin
            tick();
            chk("post reset en", {7'd0, wb_en}, 8'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
